uart_param: RTL and testbench

Parametrised full-duplex UART: independent TX and RX engines sharing one clock, with compile-time data width, parity mode, stop-bit count and baud rate. RX uses oversampling with mid-bit sampling, false-start rejection and parity/framing error reporting. Drop-in successor to the fixed 8N1 UART core, sitting between the user logic and the board pins (or looped TX→RX in the testbench).

---
 rtl/uart_param.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_param.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_param.sv
// rtl/uart_param.sv - parametrised full-duplex UART with oversampled RX
// TX and RX share only the clock and reset; each runs its own FSM and counters.
module uart_param #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 o_txd,
  output logic                 o_tx_busy,
  output logic                 o_tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_done,
  output logic                 o_rx_parity_err,
  output logic                 o_rx_frame_err
);

  localparam int   DIV      = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int   BIT_CYC  = DIV * OVERSAMPLE;
  localparam int   STOP_CYC = STOP_BITS * BIT_CYC;
  localparam int   TXC_W    = $clog2(STOP_CYC + 1);
  localparam int   DIV_W    = $clog2(DIV + 1);
  localparam int   OS_W     = $clog2(OVERSAMPLE);
  localparam int   BIT_W    = $clog2(DATA_BITS);
  localparam logic HAS_PAR  = (PARITY != 0);
  localparam logic ODD      = (PARITY == 2);

  if (DIV < 1 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_param_check
    $error("uart_param: illegal parameterisation");
  end

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [TXC_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_txd_q, tx_txd_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 tx_accept;
  logic                 tx_bit_end;

  rx_state_e            rx_state_q, rx_state_d;
  logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;
  logic                 rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_done_q, rx_done_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 tick, os_end;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + TXC_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_shreg_d = tx_shreg_q;
    tx_par_d   = tx_par_q;
    tx_txd_d   = tx_txd_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
    tx_accept  = 1'b0;
    tx_bit_end = (tx_cnt_q == TXC_W'(BIT_CYC - 1));
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d  = '0;
        tx_accept = start;
      end
      TX_START: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_txd_d   = tx_shreg_q[0];
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_shreg_d = tx_shreg_q >> 1;
        if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
          tx_state_d = HAS_PAR ? TX_PARITY : TX_STOP;
          tx_txd_d   = HAS_PAR ? tx_par_q : 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + BIT_W'(1);
          tx_txd_d = tx_shreg_q[1];
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_txd_d   = 1'b1;
        tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_cnt_q == TXC_W'(STOP_CYC - 1)) begin
        tx_cnt_d   = '0;
        tx_done_d  = 1'b1;
        tx_busy_d  = 1'b0;
        tx_state_d = TX_IDLE;
        tx_accept  = start;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // A start on the last stop cycle chains the next frame with no idle gap.
    if (tx_accept) begin
      tx_state_d = TX_START;
      tx_cnt_d   = '0;
      tx_shreg_d = tx_data;
      tx_par_d   = (^tx_data) ^ ODD;
      tx_txd_d   = 1'b0;
      tx_busy_d  = 1'b1;
    end
  end

  always_comb begin
    rx_s1_d    = rx;
    rx_s2_d    = rx_s1_q;
    tick       = (div_cnt_q == DIV_W'(DIV - 1));
    div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
    os_end     = tick && (os_cnt_q == OS_W'(OVERSAMPLE - 1));
    os_cnt_d   = tick ? os_cnt_q + OS_W'(1) : os_cnt_q;
    rx_state_d = rx_state_q;
    rx_bit_d   = rx_bit_q;
    rx_shreg_d = rx_shreg_q;
    rx_par_d   = rx_par_q;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_done_d  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: if (!rx_s2_q) begin
        os_cnt_d   = '0;
        rx_state_d = RX_START;
      end
      RX_START: if (tick && os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1)) begin
        os_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (os_end) begin
        os_cnt_d   = '0;
        rx_shreg_d = {rx_s2_q, rx_shreg_q[DATA_BITS-1:1]};
        if (rx_bit_q == BIT_W'(DATA_BITS - 1)) rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
        else rx_bit_d = rx_bit_q + BIT_W'(1);
      end
      RX_PARITY: if (os_end) begin
        os_cnt_d   = '0;
        rx_par_d   = rx_s2_q;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (os_end) begin
        os_cnt_d   = '0;
        rx_data_d  = rx_shreg_q;
        rx_perr_d  = HAS_PAR && ((^rx_shreg_q) ^ ODD ^ rx_par_q);
        rx_ferr_d  = !rx_s2_q;
        rx_done_d  = 1'b1;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_WAIT;
      end
      // After a broken stop bit the line must go high before a new start is armed.
      RX_WAIT: if (rx_s2_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shreg_q <= '0;
      tx_par_q   <= 1'b0;
      tx_txd_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      div_cnt_q  <= '0;
      os_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shreg_q <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shreg_q <= tx_shreg_d;
      tx_par_q   <= tx_par_d;
      tx_txd_q   <= tx_txd_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
      rx_state_q <= rx_state_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      div_cnt_q  <= div_cnt_d;
      os_cnt_q   <= os_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shreg_q <= rx_shreg_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign o_txd           = tx_txd_q;
  assign o_tx_busy       = tx_busy_q;
  assign o_tx_done       = tx_done_q;
  assign o_rx_data       = rx_data_q;
  assign o_rx_done       = rx_done_q;
  assign o_rx_parity_err = rx_perr_q;
  assign o_rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_param.sv
// tb/tb_uart_param.sv - self-checking bench for uart_param in 8N1, 8E1 and 8O2
`timescale 1ns/1ps
module tb_uart_param;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 10_000;
  localparam int OS     = 16;
  localparam int BIT    = 160;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      sel = 2'd0;
  logic            start_r = 1'b0;
  logic [7:0]      tx_data_r = 8'h00;
  logic            ext_mode = 1'b0;
  logic            ext_rx = 1'b1;
  logic [2:0]      st, txd, busy, done, rx_in, rx_done, perr, ferr;
  logic [2:0][7:0] rxd;

  for (genvar g = 0; g < 3; g++) begin : g_wire
    assign st[g]    = start_r && (sel == 2'(g));
    assign rx_in[g] = (ext_mode && sel == 2'(g)) ? ext_rx : txd[g];
  end

  uart_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .start(st[0]), .tx_data(tx_data_r), .o_txd(txd[0]), .o_tx_busy(busy[0]),
    .o_tx_done(done[0]), .rx(rx_in[0]), .o_rx_data(rxd[0]), .o_rx_done(rx_done[0]),
    .o_rx_parity_err(perr[0]), .o_rx_frame_err(ferr[0]));
  uart_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .start(st[1]), .tx_data(tx_data_r), .o_txd(txd[1]), .o_tx_busy(busy[1]),
    .o_tx_done(done[1]), .rx(rx_in[1]), .o_rx_data(rxd[1]), .o_rx_done(rx_done[1]),
    .o_rx_parity_err(perr[1]), .o_rx_frame_err(ferr[1]));
  uart_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_8o2 (
    .clk(clk), .reset(reset), .start(st[2]), .tx_data(tx_data_r), .o_txd(txd[2]), .o_tx_busy(busy[2]),
    .o_tx_done(done[2]), .rx(rx_in[2]), .o_rx_data(rxd[2]), .o_rx_done(rx_done[2]),
    .o_rx_parity_err(perr[2]), .o_rx_frame_err(ferr[2]));

  logic       cur_txd, cur_busy, cur_done, cur_rx_done, cur_perr, cur_ferr;
  logic [7:0] cur_rxd;
  assign cur_txd     = txd[sel];
  assign cur_busy    = busy[sel];
  assign cur_done    = done[sel];
  assign cur_rx_done = rx_done[sel];
  assign cur_perr    = perr[sel];
  assign cur_ferr    = ferr[sel];
  assign cur_rxd     = rxd[sel];

  int checks = 0;
  int passed = 0;

  // Reference frame: the line level of every bit slot, start bit first.
  bit fb [12];
  int mon_n = 0;
  logic [7:0] mon_d = 8'h00;
  logic mon_p = 1'b0, mon_f = 1'b0;

  function automatic int par_of(input logic [1:0] s);
    return (s == 2'd0) ? 0 : (s == 2'd1) ? 1 : 2;
  endfunction

  function automatic int stops_of(input logic [1:0] s);
    return (s == 2'd2) ? 2 : 1;
  endfunction

  function automatic int build_frame(input logic [7:0] d, input int par, input int stops,
                                     input bit flip, input bit stop0);
    int n = 0;
    int ones = 0;
    fb[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin
      fb[n] = d[i]; ones += int'(d[i]); n++;
    end
    if (par != 0) begin
      fb[n] = ((ones % 2) == 1) ^ (par == 2) ^ flip; n++;
    end
    for (int s = 0; s < stops; s++) begin
      fb[n] = (s == 0 && stop0) ? 1'b0 : 1'b1; n++;
    end
    return n;
  endfunction

  task automatic drive_line(input bit v, input int cycles);
    ext_rx = v;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (cur_rx_done) begin
        mon_n++; mon_d = cur_rxd; mon_p = cur_perr; mon_f = cur_ferr;
      end
    end
  endtask

  task automatic ext_frame(input logic [7:0] d, input bit flip, input bit stop0);
    int nb = build_frame(d, par_of(sel), stops_of(sel), flip, stop0);
    for (int b = 0; b < nb; b++) drive_line(fb[b], BIT);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit pre, input bit chain,
                           input logic [7:0] nd, input int poke, input string tag);
    int nb = build_frame(d, par_of(sel), stops_of(sel), 1'b0, 1'b0);
    int f = nb * BIT;
    int stop_at = (nb - stops_of(sel)) * BIT;
    int done_k = -1, rx_k = -1, rx_n = 0, werr = 0;
    logic [7:0] rd = 8'h00;
    logic rp = 1'b0, rf = 1'b0;
    if (!pre) begin
      @(negedge clk); tx_data_r = d; start_r = 1'b1;
      @(posedge clk); #1; start_r = 1'b0;
    end
    tx_data_r = ~d;
    checks++;
    if (cur_txd !== 1'b0 || cur_busy !== 1'b1)
      $display("FAIL %s_accept txd/busy got %b%b expected 01", tag, cur_txd, cur_busy);
    else passed++;
    for (int k = 1; k <= f + 5; k++) begin
      @(posedge clk); #1;
      if (poke > 0 && k == poke) start_r = 1'b1;
      if (poke > 0 && k == poke + 1) start_r = 1'b0;
      if (cur_rx_done) begin
        rx_n++; rx_k = k; rd = cur_rxd; rp = cur_perr; rf = cur_ferr;
      end
      if ((k % BIT) == BIT / 2 && (k / BIT) < nb && cur_txd !== fb[k / BIT]) werr++;
      if (cur_done) begin
        done_k = k;
        break;
      end
      if (chain && k == f - 1) begin
        tx_data_r = nd; start_r = 1'b1;
      end
    end
    if (chain) start_r = 1'b0;
    checks++;
    if (done_k !== f) $display("FAIL %s_done_cycle got %0d expected %0d", tag, done_k, f);
    else passed++;
    checks++;
    if (werr !== 0) $display("FAIL %s_txd_wave got %0d bad bits expected 0", tag, werr);
    else passed++;
    checks++;
    if (cur_busy !== chain || cur_txd !== !chain)
      $display("FAIL %s_after_done busy/txd got %b%b expected %b%b", tag, cur_busy, cur_txd, chain, !chain);
    else passed++;
    checks++;
    if (rx_n !== 1 || rd !== d || rp !== 1'b0 || rf !== 1'b0)
      $display("FAIL %s_rx got n=%0d data=%0h p=%b f=%b expected n=1 data=%0h p=0 f=0", tag, rx_n, rd, rp, rf, d);
    else passed++;
    checks++;
    if (rx_k < stop_at + 40 || rx_k > stop_at + 120)
      $display("FAIL %s_rx_latency got %0d expected %0d..%0d", tag, rx_k, stop_at + 40, stop_at + 120);
    else passed++;
  endtask

  task automatic test_reset;
    #20;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s); #1;
      checks++;
      if ({cur_txd, cur_busy, cur_done} !== 3'b100)
        $display("FAIL reset_tx_%0d got %b expected 100", s, {cur_txd, cur_busy, cur_done});
      else passed++;
      checks++;
      if ({cur_rxd, cur_rx_done, cur_perr, cur_ferr} !== 11'h000)
        $display("FAIL reset_rx_%0d got %0h expected 0", s, {cur_rxd, cur_rx_done, cur_perr, cur_ferr});
      else passed++;
    end
    @(negedge clk); reset = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_8n1;
    sel = 2'd0;
    run_frame(8'h01, 1'b0, 1'b0, 8'h00, 0, "n1_01");
    run_frame(8'hAA, 1'b0, 1'b0, 8'h00, 0, "n1_aa");
  endtask

  task automatic test_parity_modes;
    sel = 2'd1;
    run_frame(8'hAA, 1'b0, 1'b0, 8'h00, 0, "e1_aa");
    run_frame(8'h7F, 1'b0, 1'b0, 8'h00, 0, "e1_7f");
    sel = 2'd2;
    run_frame(8'hAA, 1'b0, 1'b0, 8'h00, 0, "o2_aa");
    run_frame(8'h7F, 1'b0, 1'b0, 8'h00, 0, "o2_7f");
  endtask

  task automatic test_random;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      for (int i = 0; i < 3; i++) run_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 8'h00, 0, "rand");
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a = 8'($urandom_range(0, 255));
    logic [7:0] b = 8'($urandom_range(0, 255));
    sel = 2'd0;
    run_frame(a, 1'b0, 1'b1, b, 0, "b2b_first");
    run_frame(b, 1'b1, 1'b0, 8'h00, 0, "b2b_second");
  endtask

  task automatic test_parity_error;
    sel = 2'd1; ext_rx = 1'b1; ext_mode = 1'b1;
    drive_line(1'b1, 20);
    mon_n = 0;
    ext_frame(8'h55, 1'b1, 1'b0);
    drive_line(1'b1, BIT);
    checks++;
    if (mon_n !== 1 || mon_d !== 8'h55 || mon_p !== 1'b1 || mon_f !== 1'b0)
      $display("FAIL parity_flip got n=%0d data=%0h p=%b f=%b expected n=1 data=55 p=1 f=0", mon_n, mon_d, mon_p, mon_f);
    else passed++;
    mon_n = 0;
    ext_frame(8'h55, 1'b0, 1'b0);
    drive_line(1'b1, BIT);
    checks++;
    if (mon_n !== 1 || mon_d !== 8'h55 || mon_p !== 1'b0 || mon_f !== 1'b0)
      $display("FAIL parity_clean got n=%0d data=%0h p=%b f=%b expected n=1 data=55 p=0 f=0", mon_n, mon_d, mon_p, mon_f);
    else passed++;
    ext_mode = 1'b0;
  endtask

  task automatic test_frame_error;
    sel = 2'd0; ext_rx = 1'b1; ext_mode = 1'b1;
    drive_line(1'b1, 20);
    mon_n = 0;
    ext_frame(8'h3C, 1'b0, 1'b1);
    drive_line(1'b0, 2000);
    checks++;
    if (mon_n !== 1 || mon_d !== 8'h3C || mon_p !== 1'b0 || mon_f !== 1'b1)
      $display("FAIL frame_err got n=%0d data=%0h p=%b f=%b expected n=1 data=3c p=0 f=1", mon_n, mon_d, mon_p, mon_f);
    else passed++;
    drive_line(1'b1, 2 * BIT);
    mon_n = 0;
    drive_line(1'b0, 40);
    drive_line(1'b1, 2000);
    checks++;
    if (mon_n !== 0 || cur_ferr !== 1'b1 || cur_rxd !== 8'h3C)
      $display("FAIL false_start got n=%0d f=%b data=%0h expected n=0 f=1 data=3c", mon_n, cur_ferr, cur_rxd);
    else passed++;
    mon_n = 0;
    ext_frame(8'h3C, 1'b0, 1'b0);
    drive_line(1'b1, BIT);
    checks++;
    if (mon_n !== 1 || mon_d !== 8'h3C || mon_f !== 1'b0)
      $display("FAIL frame_clean got n=%0d data=%0h f=%b expected n=1 data=3c f=0", mon_n, mon_d, mon_f);
    else passed++;
    ext_mode = 1'b0;
  endtask

  task automatic test_ignored_start;
    int extra = 0;
    int busy_hi = 0;
    sel = 2'd0;
    run_frame(8'h5A, 1'b0, 1'b0, 8'h00, 800, "poke");
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (cur_done) extra++;
      if (cur_busy) busy_hi++;
    end
    checks++;
    if (extra !== 0 || busy_hi !== 0)
      $display("FAIL poke_single_done got extra=%0d busy=%0d expected 0 0", extra, busy_hi);
    else passed++;
  endtask

  task automatic test_reset_midframe;
    sel = 2'd0;
    @(negedge clk); tx_data_r = 8'hA5; start_r = 1'b1;
    @(posedge clk); #1; start_r = 1'b0;
    repeat (500) @(posedge clk);
    #2; reset = 1'b0; #1;
    checks++;
    if (cur_txd !== 1'b1 || cur_busy !== 1'b0)
      $display("FAIL midreset_tx got txd=%b busy=%b expected 1 0", cur_txd, cur_busy);
    else passed++;
    checks++;
    if (cur_rxd !== 8'h00 || cur_ferr !== 1'b0 || cur_rx_done !== 1'b0)
      $display("FAIL midreset_rx got data=%0h f=%b done=%b expected 0 0 0", cur_rxd, cur_ferr, cur_rx_done);
    else passed++;
    #20;
    @(negedge clk); reset = 1'b1;
    repeat (10) @(posedge clk);
    run_frame(8'hC3, 1'b0, 1'b0, 8'h00, 0, "post_reset");
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog expired at %0t expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b0;
    test_reset;
    test_8n1;
    test_parity_modes;
    test_random;
    test_back_to_back;
    test_parity_error;
    test_frame_error;
    test_ignored_start;
    test_reset_midframe;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
